imem_loader: RTL and testbench

Parametrised instruction memory and program sequencer for the `rv32i` single-cycle core, replacing hard-coded per-cycle instruction stimulus. It sits between the core's `pc` output and `instr` input. A program is loaded at run time over a valid/ready word stream, then the core is released. Execution stops on `ebreak`. The block reports run-cycle count and sticky fetch faults.

---
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory and program sequencer for the rv32i core: streams a program in,
// releases the core, stops on ebreak, and reports run-cycle count and fetch faults.
module imem_loader #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned PC_W       = 16,
  parameter logic [31:0] NOP        = 32'h00000013,
  parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_W-1:0]        pc,
  output logic [31:0]            instr,
  output logic                   core_run,
  input  logic                   load_start,
  input  logic [$clog2(DEPTH):0] load_count,
  input  logic                   load_valid,
  input  logic [31:0]            load_data,
  output logic                   load_ready,
  output logic                   halted,
  output logic                   fault,
  output logic [31:0]            run_cycles
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = PC_W - 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   len_cap;
  logic            cyc_clr;
  logic            core_run_q, load_ready_q, halted_q, fault_q;
  logic [31:0]     run_cycles_q;
  logic [31:0]     mem [DEPTH];

  logic [WW-1:0]   w;
  logic            in_range, fetch_ok;

  assign w        = pc[PC_W-1:2];
  assign in_range = ({{CW{1'b0}}, w} < {{WW{1'b0}}, len_q});
  assign fetch_ok = (state_q == RUN) && (pc[1:0] == 2'b00) && in_range;
  assign instr    = fetch_ok ? mem[w[AW-1:0]] : NOP;

  assign len_cap  = (load_count > CW'(DEPTH)) ? CW'(DEPTH) : load_count;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    cyc_clr = 1'b0;
    unique case (state_q)
      IDLE, HALT, RUN: begin
        // A new load request outranks a halt fetched in the same RUN cycle.
        if (load_start) begin
          cyc_clr = 1'b1;
          if (load_count != '0) begin
            state_d = LOAD;
            len_d   = len_cap;
            wptr_d  = '0;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == RUN && instr == HALT_INSTR) begin
          state_d = HALT;
        end
      end
      LOAD: begin
        if (load_valid) begin
          wptr_d = wptr_q + 1'b1;
          if (wptr_q + 1'b1 == len_q) state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      wptr_q       <= '0;
      core_run_q   <= 1'b0;
      load_ready_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wptr_q       <= wptr_d;
      core_run_q   <= (state_d == RUN);
      load_ready_q <= (state_d == LOAD);
      halted_q     <= (state_d == HALT);
      if (state_d == LOAD && state_q != LOAD)
        fault_q <= 1'b0;
      else if (state_q == RUN && !fetch_ok)
        fault_q <= 1'b1;
      if (cyc_clr)
        run_cycles_q <= '0;
      else if (state_q == RUN && run_cycles_q != '1)
        run_cycles_q <= run_cycles_q + 32'd1;
    end
  end

  // Program storage is deliberately not reset; len gates every read instead.
  always_ff @(posedge clk) begin
    if (!rst && state_q == LOAD && load_valid)
      mem[wptr_q[AW-1:0]] <= load_data;
  end

  assign core_run   = core_run_q;
  assign load_ready = load_ready_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader (DEPTH=8) against a behavioural fetch model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = 16;
  localparam logic [31:0] NOPW  = 32'h00000013;
  localparam logic [31:0] HALTW = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [31:0] instr;
  logic        core_run;
  logic        load_start;
  logic [3:0]  load_count;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        halted;
  logic        fault;
  logic [31:0] run_cycles;

  imem_loader #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP(NOPW), .HALT_INSTR(HALTW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .core_run(core_run),
    .load_start(load_start), .load_count(load_count), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .halted(halted),
    .fault(fault), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  int          len_m;
  bit          run_m;
  bit          fault_m;
  int          rc_m;
  int          acc;

  function automatic logic [31:0] exp_instr(input logic [15:0] p);
    if (run_m && p[1:0] == 2'b00 && int'(p >> 2) < len_m) return mem_m[p >> 2];
    return NOPW;
  endfunction

  function automatic bit bad_fetch(input logic [15:0] p);
    return (p[1:0] != 2'b00) || (int'(p >> 2) >= len_m);
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] v;
    v = $urandom;
    if (v == HALTW) v = v ^ 32'h1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [4];
  logic [15:0] pcs  [6];
  logic [4:0]  pat;

  initial begin
    prog[0] = 32'h00300413; prog[1] = 32'h00340413;
    prog[2] = 32'h00240413; prog[3] = HALTW;
    pcs[0] = 16'd0; pcs[1] = 16'd2; pcs[2] = 16'd12;
    pcs[3] = 16'd0; pcs[4] = 16'd4; pcs[5] = 16'd8;
    len_m = 0; run_m = 0; fault_m = 0; rc_m = 0;

    rst = 1'b1; pc = '0; load_start = 1'b0; load_count = '0;
    load_valid = 1'b0; load_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_core_run", {31'b0, core_run}, 32'd0);
    chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    chk("rst_instr", instr, NOPW);

    // Four-word program with continuous valid, then run to ebreak
    load_start = 1'b1; load_count = 4'd4;
    tick();
    load_start = 1'b0;
    chk("t1_load_ready", {31'b0, load_ready}, 32'd1);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog[i];
      #1;
      chk("t1_core_run_during_load", {31'b0, core_run}, 32'd0);
      if (load_valid && load_ready) begin mem_m[acc] = load_data; acc++; end
      tick();
    end
    load_valid = 1'b0;
    #1;
    chk("t1_accepts", acc, 32'd4);
    chk("t1_core_run_rise", {31'b0, core_run}, 32'd1);
    len_m = 4; run_m = 1; rc_m = 0;
    for (int i = 0; i < 4; i++) begin
      pc = 16'(i * 4);
      #1;
      chk("t1_instr", instr, exp_instr(pc));
      chk("t1_core_run", {31'b0, core_run}, 32'd1);
      tick();
      rc_m++;
    end
    run_m = 0;
    chk("t1_halted", {31'b0, halted}, 32'd1);
    chk("t1_core_run_halt", {31'b0, core_run}, 32'd0);
    chk("t1_run_cycles", run_cycles, 32'(rc_m));
    chk("t1_fault", {31'b0, fault}, 32'd0);
    chk("t1_instr_halt", instr, NOPW);

    // Restart old program from HALT with load_count=0
    pc = 16'd0; load_start = 1'b1; load_count = 4'd0;
    tick();
    load_start = 1'b0; run_m = 1; rc_m = 0;
    chk("t2_core_run", {31'b0, core_run}, 32'd1);
    chk("t2_halted", {31'b0, halted}, 32'd0);
    chk("t2_run_cycles", run_cycles, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pc = 16'(i * 4);
      #1;
      chk("t2_instr", instr, exp_instr(pc));
      tick();
      rc_m++;
    end
    run_m = 0;
    chk("t2_halted_again", {31'b0, halted}, 32'd1);
    chk("t2_run_cycles", run_cycles, 32'(rc_m));

    // Three random words with valid toggling 1,0,1,0,1
    load_start = 1'b1; load_count = 4'd3;
    tick();
    load_start = 1'b0; rc_m = 0; fault_m = 0;
    pat = 5'b10101; acc = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = pat[i]; load_data = rnd_word();
      #1;
      chk("t3_core_run_during_load", {31'b0, core_run}, 32'd0);
      if (load_valid && load_ready) begin mem_m[acc] = load_data; acc++; end
      tick();
    end
    load_valid = 1'b0;
    #1;
    chk("t3_accepts", acc, 32'd3);
    chk("t3_core_run_rise", {31'b0, core_run}, 32'd1);
    len_m = 3; run_m = 1;
    for (int i = 0; i < 6; i++) begin
      pc = pcs[i];
      #1;
      chk("t3_instr", instr, exp_instr(pc));
      chk("t3_fault_pre", {31'b0, fault}, {31'b0, fault_m});
      tick();
      rc_m++;
      if (bad_fetch(pc)) fault_m = 1;
    end
    chk("t3_fault_sticky", {31'b0, fault}, {31'b0, fault_m});
    chk("t3_run_cycles", run_cycles, 32'(rc_m));

    // load_count = DEPTH+1 saturates to DEPTH words
    pc = 16'd0; load_start = 1'b1; load_count = 4'(DEPTH + 1);
    tick();
    load_start = 1'b0; run_m = 0; fault_m = 0; rc_m = 0;
    chk("t4_load_ready", {31'b0, load_ready}, 32'd1);
    chk("t4_fault_cleared", {31'b0, fault}, 32'd0);
    chk("t4_run_cycles_cleared", run_cycles, 32'd0);
    acc = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_valid = 1'b1; load_data = rnd_word();
      #1;
      chk("t4_core_run_during_load", {31'b0, core_run}, 32'd0);
      if (load_valid && load_ready) begin mem_m[acc] = load_data; acc++; end
      tick();
    end
    load_valid = 1'b0;
    #1;
    chk("t4_accepts", acc, DEPTH);
    chk("t4_core_run_rise", {31'b0, core_run}, 32'd1);
    chk("t4_load_ready_drop", {31'b0, load_ready}, 32'd0);
    len_m = DEPTH; run_m = 1;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      pc = 16'(i * 4);
      #1;
      chk("t4_instr", instr, exp_instr(pc));
      tick();
      rc_m++;
      if (bad_fetch(pc)) fault_m = 1;
    end
    chk("t4_fault", {31'b0, fault}, {31'b0, fault_m});
    chk("t4_run_cycles", run_cycles, 32'(rc_m));

    // Reset in the middle of a six-word load
    pc = 16'd0; load_start = 1'b1; load_count = 4'd6;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = rnd_word();
      mem_m[i] = load_data;
      tick();
    end
    load_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; len_m = 0; run_m = 0; fault_m = 0; rc_m = 0;
    #1;
    chk("t5_load_ready", {31'b0, load_ready}, 32'd0);
    chk("t5_core_run", {31'b0, core_run}, 32'd0);
    chk("t5_fault", {31'b0, fault}, 32'd0);
    chk("t5_run_cycles", run_cycles, 32'd0);
    chk("t5_instr", instr, exp_instr(pc));

    // Run with len=0 after reset: every fetch is NOP and faults
    load_start = 1'b1; load_count = 4'd0;
    tick();
    load_start = 1'b0; run_m = 1;
    chk("t6_core_run", {31'b0, core_run}, 32'd1);
    chk("t6_instr", instr, exp_instr(pc));
    tick();
    rc_m++;
    if (bad_fetch(pc)) fault_m = 1;
    chk("t6_fault", {31'b0, fault}, {31'b0, fault_m});
    chk("t6_run_cycles", run_cycles, 32'(rc_m));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
